program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/loader_pkg.sv | 20 ++
 rtl/word_assembler.sv | 33 +++
 rtl/program_loader.sv | 164 ++++++++++++++++
 tb/tb_program_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the serial program loader: FSM encoding and default load address.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_HI  = 3'd1,
        S_LEN_LO  = 3'd2,
        S_COLLECT = 3'd3,
        S_WRITE   = 3'd4,
        S_DONE    = 3'd5,
        S_ERROR   = 3'd6
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h0040_0000;

    function automatic logic state_accepts_bytes(input state_t s);
        return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_COLLECT);
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Big-endian byte-to-word assembler: keeps the three most recent bytes and a 2-bit byte counter.
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        last_o
);

    logic [23:0] word_q;
    logic [1:0]  cnt_q;

    // Shift register and byte counter; restart clears both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= 24'd0;
            cnt_q  <= 2'd0;
        end else if (clear_i) begin
            word_q <= 24'd0;
            cnt_q  <= 2'd0;
        end else if (shift_i) begin
            word_q <= {word_q[15:0], byte_i};
            cnt_q  <= cnt_q + 2'd1;
        end
    end

    // word_o is the word completed if byte_i is accepted now as the fourth byte.
    assign word_o = {word_q, byte_i};
    assign last_o = (cnt_q == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Serial program loader: reads a 16-bit big-endian word count and that many big-endian
// words, writes them to instruction memory, and holds the CPU in reset until done.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned MEMORY_DEPTH = 32,
    parameter logic [31:0] BASE_ADDRESS = DEFAULT_BASE_ADDRESS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [7:0]  ByteIn,
    input  logic        ByteValid,
    output logic        ByteReady,
    output logic        MemWrite,
    output logic [31:0] WriteAddress,
    output logic [31:0] WriteData,
    output logic        CpuReset,
    output logic        Done,
    output logic        Error
);

    localparam int unsigned CNT_W = $clog2(MEMORY_DEPTH + 1);

    state_t             state_q, state_d;
    logic [15:0]        len_q, len_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [15:0]        hdr_n_s;
    logic [31:0]        word_next_s;
    logic               byte_fire_s;
    logic               asm_clear_s;
    logic               asm_shift_s;
    logic               asm_last_s;
    logic [31:0]        asm_word_s;

    logic               byte_ready_q;
    logic               mem_write_q;
    logic [31:0]        write_address_q;
    logic [31:0]        write_data_q;
    logic               cpu_reset_q;
    logic               done_q;
    logic               error_q;

    assign byte_fire_s = ByteValid & byte_ready_q;
    assign hdr_n_s     = {len_q[15:8], ByteIn};
    assign word_next_s = 32'(word_cnt_q) + 32'd1;

    word_assembler u_asm (
        .clk     (clk),
        .reset   (reset),
        .clear_i (asm_clear_s),
        .shift_i (asm_shift_s),
        .byte_i  (ByteIn),
        .word_o  (asm_word_s),
        .last_o  (asm_last_s)
    );

    // State, header count and word counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            len_q      <= 16'd0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Next-state logic; Start is honoured only from the resting states.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        asm_clear_s = 1'b0;
        asm_shift_s = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (Start) begin
                    state_d     = S_LEN_HI;
                    len_d       = 16'd0;
                    word_cnt_d  = '0;
                    asm_clear_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            S_LEN_HI: begin
                if (byte_fire_s) begin
                    len_d   = {ByteIn, 8'h00};
                    state_d = S_LEN_LO;
                end else begin
                    state_d = state_q;
                end
            end
            S_LEN_LO: begin
                if (byte_fire_s) begin
                    len_d = hdr_n_s;
                    if (hdr_n_s == 16'd0) begin
                        state_d = S_DONE;
                    end else if (32'(hdr_n_s) > 32'(MEMORY_DEPTH)) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_COLLECT: begin
                if (byte_fire_s) begin
                    asm_shift_s = 1'b1;
                    state_d     = asm_last_s ? S_WRITE : S_COLLECT;
                end else begin
                    state_d = state_q;
                end
            end
            S_WRITE: begin
                word_cnt_d = CNT_W'(word_next_s);
                if (word_next_s == {16'd0, len_q}) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_COLLECT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_ready_q    <= 1'b0;
            mem_write_q     <= 1'b0;
            write_address_q <= BASE_ADDRESS;
            write_data_q    <= 32'd0;
            cpu_reset_q     <= 1'b1;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            byte_ready_q <= state_accepts_bytes(state_d);
            mem_write_q  <= (state_d == S_WRITE);
            cpu_reset_q  <= (state_d != S_DONE);
            done_q       <= (state_d == S_DONE);
            error_q      <= (state_d == S_ERROR);
            if (state_d == S_WRITE) begin
                write_address_q <= BASE_ADDRESS + (32'(word_cnt_q) << 2);
                write_data_q    <= asm_word_s;
            end
        end
    end

    assign ByteReady    = byte_ready_q;
    assign MemWrite     = mem_write_q;
    assign WriteAddress = write_address_q;
    assign WriteData    = write_data_q;
    assign CpuReset     = cpu_reset_q;
    assign Done         = done_q;
    assign Error        = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus randomized loads
// compared against a list-of-writes reference model.
module tb_program_loader;

    localparam int          DEPTH = 32;
    localparam logic [31:0] BASE  = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [7:0]  ByteIn;
    logic        ByteValid;
    logic        ByteReady;
    logic        MemWrite;
    logic [31:0] WriteAddress;
    logic [31:0] WriteData;
    logic        CpuReset;
    logic        Done;
    logic        Error;

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_viol = 0;

    logic [31:0] words_q  [$];
    logic [31:0] exp_addr [$];
    logic [31:0] exp_data [$];
    logic [31:0] got_addr [$];
    logic [31:0] got_data [$];

    program_loader #(.MEMORY_DEPTH(DEPTH), .BASE_ADDRESS(BASE)) dut (
        .clk          (clk),
        .reset        (reset),
        .Start        (Start),
        .ByteIn       (ByteIn),
        .ByteValid    (ByteValid),
        .ByteReady    (ByteReady),
        .MemWrite     (MemWrite),
        .WriteAddress (WriteAddress),
        .WriteData    (WriteData),
        .CpuReset     (CpuReset),
        .Done         (Done),
        .Error        (Error)
    );

    always #5 clk = ~clk;

    // Capture every write strobe; ByteReady must be low while writing.
    always @(negedge clk) begin
        if (MemWrite === 1'b1) begin
            got_addr.push_back(WriteAddress);
            got_data.push_back(WriteData);
            if (ByteReady !== 1'b0) rdy_viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int gap_for(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        return int'($urandom_range(0, 2));
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        ByteValid = 1'b0;
        repeat (gap) begin
            ByteIn = 8'($urandom);
            @(negedge clk);
        end
        ByteValid = 1'b1;
        ByteIn    = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (ByteReady === 1'b1) ok = 1'b1;
            @(negedge clk);
        end
        ByteValid = 1'b0;
        ByteIn    = 8'($urandom);
        check("byte_accept", 32'(ok), 32'd1);
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        check("start_ready", 32'(ByteReady), 32'd1);
        check("start_cpurst", 32'(CpuReset), 32'd1);
        check("start_done", 32'(Done), 32'd0);
        check("start_error", 32'(Error), 32'd0);
    endtask

    task automatic compare_writes(input string tag);
        int n;
        check({tag, "_nwrites"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_addr"}, got_addr[i], exp_addr[i]);
            check({tag, "_data"}, got_data[i], exp_data[i]);
        end
        got_addr.delete(); got_data.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    // Load of header n followed by words_q; glitch_at pulses Start before that data byte,
    // abort_at returns after that many data bytes without finishing the load.
    task automatic run_load(input string tag, input logic [15:0] n, input int gap_mode,
                            input int glitch_at, input int abort_at);
        logic [31:0] w;
        bit legal;
        bit ok;
        int bi;
        legal = (n != 16'd0) && (int'(n) <= DEPTH);
        pulse_start();
        send_byte(n[15:8], gap_mode == 1 ? 0 : gap_for(gap_mode));
        send_byte(n[7:0], gap_for(gap_mode));
        bi = 0;
        if (legal) begin
            for (int k = 0; k < int'(n); k++) begin
                w = words_q[k];
                for (int j = 0; j < 4; j++) begin
                    if (bi == abort_at) return;
                    if (bi == glitch_at) begin
                        Start = 1'b1;
                        @(negedge clk);
                        Start = 1'b0;
                    end
                    send_byte(w[31 - 8*j -: 8], gap_for(gap_mode));
                    bi++;
                end
                exp_addr.push_back(BASE + 32'(4 * k));
                exp_data.push_back(w);
            end
        end
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (Done === 1'b1 || Error === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_finished"}, 32'(ok), 32'd1);
        compare_writes(tag);
        check({tag, "_done"}, 32'(Done), (int'(n) <= DEPTH) ? 32'd1 : 32'd0);
        check({tag, "_error"}, 32'(Error), (int'(n) > DEPTH) ? 32'd1 : 32'd0);
        check({tag, "_cpurst"}, 32'(CpuReset), (int'(n) <= DEPTH) ? 32'd0 : 32'd1);
        check({tag, "_ready"}, 32'(ByteReady), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(ByteReady), 32'd0);
        check({tag, "_memwr"}, 32'(MemWrite), 32'd0);
        check({tag, "_addr"}, WriteAddress, BASE);
        check({tag, "_data"}, WriteData, 32'd0);
        check({tag, "_cpurst"}, 32'(CpuReset), 32'd1);
        check({tag, "_done"}, 32'(Done), 32'd0);
        check({tag, "_error"}, 32'(Error), 32'd0);
    endtask

    task automatic fill_words(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back(32'($urandom));
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; ByteValid = 1'b0; ByteIn = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("idle");

        // Reference program of two words, back-to-back bytes.
        words_q = '{32'h2008_0005, 32'h3C01_1001};
        run_load("basic", 16'd2, 0, -1, -1);

        // Same program with ByteValid toggling every cycle.
        run_load("toggle", 16'd2, 1, -1, -1);
        check("ready_during_write", 32'(rdy_viol), 32'd0);

        // Empty program goes straight to DONE.
        run_load("empty", 16'd0, 0, -1, -1);

        // One word over the limit, then restart and load exactly the limit.
        run_load("overflow", 16'(DEPTH + 1), 0, -1, -1);
        fill_words(DEPTH);
        run_load("full", 16'(DEPTH), 2, -1, -1);

        // Start pulses in the middle of collection are ignored.
        fill_words(3);
        run_load("glitch", 16'd3, 0, 5, -1);

        // Reset after two data bytes, then a clean single-word reload.
        words_q = '{32'hDEAD_BEEF};
        run_load("abort", 16'd1, 0, -1, 2);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        reset = 1'b0;
        repeat (4) begin
            ByteValid = 1'b1;
            ByteIn = 8'($urandom);
            @(negedge clk);
        end
        ByteValid = 1'b0;
        compare_writes("after_reset");
        run_load("reload", 16'd1, 0, -1, -1);

        // Randomized loads with random gaps.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(1, 8));
            fill_words(n);
            run_load("random", 16'(n), 2, -1, -1);
        end
        check("ready_during_write_final", 32'(rdy_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
